sram_axi_bridge: RTL and testbench
==================================

Name: sram_axi_bridge

Overview:
- Converts the core's two sram-like request ports (instruction fetch, data load/store) into one AXI3 master.
- Sits directly downstream of the CPU top, between the core and the SoC AXI interconnect.
- Strictly one outstanding transaction; data side has priority.
- Fixed AXI fields are driven by the integration top from package constants: id=0, len=0, burst=INCR, lock/cache/prot=0, wid=0, wlast=1.

Parameters:
DATA_PRIO, 1, 1 = data request wins a same-cycle conflict; 0 = instruction wins.

Ports:
clk  in  1  system clock; all state changes on rising edge
resetn  in  1  asynchronous active-low reset
inst_req  in  1  fetch request (read only), held until inst_addr_ok
inst_addr  in  32  fetch byte address
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  one-cycle pulse, inst_rdata valid
inst_rdata  out  32  fetched word
data_req  in  1  data request, held until data_addr_ok
data_wr  in  1  1 = store, 0 = load
data_size  in  2  0 = byte, 1 = half, 2 = word
data_wstrb  in  4  store byte enables
data_addr  in  32  data byte address
data_wdata  in  32  store data
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  one-cycle pulse: load data valid or store completed
data_rdata  out  32  load data
araddr  out  32  AXI read address
arsize  out  3  AXI read size
arvalid  out  1  AXI read-address valid
arready  in  1  AXI read-address ready
rdata  in  32  AXI read data
rvalid  in  1  AXI read-data valid
rready  out  1  AXI read-data ready
awaddr  out  32  AXI write address
awsize  out  3  AXI write size
awvalid  out  1  AXI write-address valid
awready  in  1  AXI write-address ready
wdata  out  32  AXI write data
wstrb  out  4  AXI write strobes
wvalid  out  1  AXI write-data valid
wready  in  1  AXI write-data ready
bvalid  in  1  AXI write-response valid
bready  out  1  AXI write-response ready

Behaviour:
- States: IDLE, AR, R, W (AW and W channels together), B.
- Reset: state=IDLE. Every valid, ready, addr_ok and data_ok output = 0. Latched addr/size/wdata/wstrb and the shared rdata register = 0.
- IDLE grant:
  - DATA_PRIO=1: data_req wins, otherwise inst_req.
  - The grant drives the winning port's addr_ok combinationally; the loser sees 0.
  - On the handshake: latch addr, size (inst: 2), wdata, wstrb and source. Next state is AR for reads/fetches, W for stores.
- AR: arvalid=1 until arready. Then go to R.
- R: rready=1. On rvalid, latch rdata and return to IDLE.
- W:
  - awvalid and wvalid assert together in the first W cycle.
  - Each drops independently after its own handshake; aw_done/w_done flags track this.
  - When both are done, go to B.
- B: bready=1. On bvalid, return to IDLE.
- data_ok:
  - Registered pulse, exactly one cycle, in the cycle after the R or B handshake.
  - Only the owning port's data_ok asserts.
  - rdata stays stable until the next completion.
- A new addr_ok may coincide with a data_ok pulse.
- Minimum latency with ready/valid always high:
  - read: addr_ok cycle 0 -> data_ok cycle 3
  - write: data_ok cycle 3
- arsize/awsize = {1'b0, latched size}. Addresses are passed through unaligned. wstrb is passed as given, even 4'b0000.
- rready/bready are 0 outside R/B, so stray responses are held off.
- rresp/bresp are not inspected.
- Request dropped before addr_ok: no effect.
- The losing request stays pending and is served in the next IDLE cycle.
- resetn low mid-transaction: immediate return to IDLE with all valids low. This AXI abort is acceptable because the whole SoC resets together.

Decomposition:
- Shared package holds:
  - state encoding
  - size codes (SZ_BYTE/HALF/WORD)
  - AXI fixed-field constants (AXI_ID=0, LEN=0, BURST_INCR=2'b01)
- Single flat module; no sub-module is natural.

Test Plan:
- inst_req addr 0xBFC00000, arready=1, rvalid one cycle later with 0x3C1DBFC0 -> inst_addr_ok cycle 0, arvalid cycle 1 with araddr 0xBFC00000 and arsize 2, inst_data_ok and inst_rdata=0x3C1DBFC0 in cycle 3.
- inst_req and data_req (load 0x80001000) in the same cycle, DATA_PRIO=1 -> data_addr_ok=1 and inst_addr_ok=0; the fetch is accepted in the cycle data_data_ok pulses.
- Store: size 0, wstrb 0100, addr 0x80000002, wdata 0x00AA0000; awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles, bready only after both handshakes, one data_data_ok pulse after bvalid.
- arready low 5 cycles then rvalid with delay -> arvalid and araddr stable throughout, no data_ok before rvalid, exactly one pulse.
- resetn low while in R -> all outputs 0 asynchronously, state IDLE; after release, a new inst_req is accepted normally.
- Back-to-back loads, all ready signals high -> accepts spaced 3 cycles apart, data_ok one per request, in order, correct rdata.

Source files
------------

// File: rtl/sram_axi_bridge_pkg.sv
// Shared types and constants for the sram-to-AXI3 bridge.
// Fixed AXI fields are tied off by the integration top from here.
package sram_axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_W,
        ST_B
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [3:0] AXI_ID         = 4'd0;
    localparam logic [3:0] AXI_LEN        = 4'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_LOCK       = 2'b00;
    localparam logic [3:0] AXI_CACHE      = 4'd0;
    localparam logic [2:0] AXI_PROT       = 3'd0;

    function automatic logic [2:0] to_axsize(input logic [1:0] sz);
        return {1'b0, sz};
    endfunction

endpackage

// File: rtl/sram_axi_bridge.sv
// Bridges the core's fetch and data sram-like ports onto one AXI3
// master, one transaction outstanding at a time.
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter bit DATA_PRIO = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [1:0]  size_q;
    logic [3:0]  wstrb_q;
    logic        src_inst_q;
    logic        aw_done_q, w_done_q;
    logic        inst_ok_q, data_ok_q;
    logic        grant_data, grant_inst, accept;
    logic        r_hs, b_hs;

    // Arbitrate the two request ports while idle.
    always_comb begin
        grant_data = 1'b0;
        grant_inst = 1'b0;
        if (state_q == ST_IDLE) begin
            grant_data = data_req && (DATA_PRIO || !inst_req);
            grant_inst = inst_req && !grant_data;
        end
    end

    assign accept       = grant_data || grant_inst;
    assign data_addr_ok = grant_data;
    assign inst_addr_ok = grant_inst;
    assign r_hs         = (state_q == ST_R) && rvalid;
    assign b_hs         = (state_q == ST_B) && bvalid;

    // Next state and AXI handshake outputs.
    always_comb begin
        state_d = state_q;
        arvalid = 1'b0;
        rready  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_data)
                    state_d = data_wr ? ST_W : ST_AR;
                else if (grant_inst)
                    state_d = ST_AR;
            end
            ST_AR: begin
                arvalid = 1'b1;
                if (arready)
                    state_d = ST_R;
            end
            ST_R: begin
                rready = 1'b1;
                if (rvalid)
                    state_d = ST_IDLE;
            end
            ST_W: begin
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
                if ((aw_done_q || awready) && (w_done_q || wready))
                    state_d = ST_B;
            end
            ST_B: begin
                bready = 1'b1;
                if (bvalid)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Capture the accepted request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q     <= '0;
            size_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            src_inst_q <= 1'b0;
        end else if (accept) begin
            addr_q     <= grant_data ? data_addr : inst_addr;
            size_q     <= grant_data ? data_size : SZ_WORD;
            wdata_q    <= data_wdata;
            wstrb_q    <= data_wstrb;
            src_inst_q <= grant_inst;
        end
    end

    // Track AW and W handshakes separately within a write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (accept) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (state_q == ST_W) begin
            if (awready)
                aw_done_q <= 1'b1;
            if (wready)
                w_done_q <= 1'b1;
        end
    end

    // Read data register and one-cycle completion pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q   <= '0;
            inst_ok_q <= 1'b0;
            data_ok_q <= 1'b0;
        end else begin
            if (r_hs)
                rdata_q <= rdata;
            inst_ok_q <= (r_hs || b_hs) && src_inst_q;
            data_ok_q <= (r_hs || b_hs) && !src_inst_q;
        end
    end

    assign araddr       = addr_q;
    assign awaddr       = addr_q;
    assign arsize       = to_axsize(size_q);
    assign awsize       = to_axsize(size_q);
    assign wdata        = wdata_q;
    assign wstrb        = wstrb_q;
    assign inst_rdata   = rdata_q;
    assign data_rdata   = rdata_q;
    assign inst_data_ok = inst_ok_q;
    assign data_data_ok = data_ok_q;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge with a transaction-level model
// and a delay-configurable AXI slave.
module tb_sram_axi_bridge;

    localparam bit DATA_PRIO = 1'b1;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [1:0]  data_size = '0;
    logic [3:0]  data_wstrb = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [2:0]  arsize, awsize;
    logic [3:0]  wstrb;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_axi_bridge #(.DATA_PRIO(DATA_PRIO)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid),
        .arready(arready), .rdata(rdata), .rvalid(rvalid),
        .rready(rready), .awaddr(awaddr), .awsize(awsize),
        .awvalid(awvalid), .awready(awready), .wdata(wdata),
        .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (a == 32'hBFC00000)
            return 32'h3C1DBFC0;
        return a ^ 32'hA5A50000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // AXI slave with per-channel delays
    int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    logic r_ph, b_ph, aw_seen, w_seen;
    logic [31:0] r_addr;

    assign arready = arvalid && (ar_cnt >= ar_dly);
    assign rvalid  = r_ph && (r_cnt >= r_dly);
    assign rdata   = memval(r_addr);
    assign awready = awvalid && (aw_cnt >= aw_dly);
    assign wready  = wvalid && (w_cnt >= w_dly);
    assign bvalid  = b_ph && (b_cnt >= b_dly);

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
            r_ph <= 1'b0; b_ph <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0;
            r_addr <= '0;
        end else begin
            ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            if (arvalid && arready) begin
                r_ph <= 1'b1; r_cnt <= 0; r_addr <= araddr;
            end else if (r_ph) begin
                if (rvalid && rready) r_ph <= 1'b0;
                else r_cnt <= r_cnt + 1;
            end
            if (awvalid && awready) aw_seen <= 1'b1;
            if (wvalid && wready) w_seen <= 1'b1;
            if (!b_ph && (aw_seen || (awvalid && awready))
                      && (w_seen || (wvalid && wready))) begin
                b_ph <= 1'b1; b_cnt <= 0;
                aw_seen <= 1'b0; w_seen <= 1'b0;
            end else if (b_ph) begin
                if (bvalid && bready) b_ph <= 1'b0;
                else b_cnt <= b_cnt + 1;
            end
        end
    end

    // Transaction-level model of the bridge
    bit m_busy, m_inst, m_wr, m_ar, m_aw, m_w, m_pend, m_pinst;
    logic [31:0] m_addr, m_wdata, m_hold;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    int cnt_ar, cnt_aw, cnt_w, cnt_dok;

    always @(negedge clk) begin : compare
        bit e_iaok, e_daok, e_arv, e_rr, e_awv, e_wv, e_br;
        bit resp;
        if (!resetn) begin
            m_busy = 0; m_pend = 0; m_hold = '0;
            m_ar = 0; m_aw = 0; m_w = 0; m_wr = 0;
        end
        e_daok = resetn && !m_busy && data_req
                 && (DATA_PRIO || !inst_req);
        e_iaok = resetn && !m_busy && inst_req && !e_daok;
        e_arv  = m_busy && !m_wr && !m_ar;
        e_rr   = m_busy && !m_wr && m_ar;
        e_awv  = m_busy && m_wr && !m_aw;
        e_wv   = m_busy && m_wr && !m_w;
        e_br   = m_busy && m_wr && m_aw && m_w;
        chk("inst_addr_ok", inst_addr_ok, e_iaok);
        chk("data_addr_ok", data_addr_ok, e_daok);
        chk("arvalid", arvalid, e_arv);
        chk("rready", rready, e_rr);
        chk("awvalid", awvalid, e_awv);
        chk("wvalid", wvalid, e_wv);
        chk("bready", bready, e_br);
        chk("inst_data_ok", inst_data_ok, m_pend && m_pinst);
        chk("data_data_ok", data_data_ok, m_pend && !m_pinst);
        chk("inst_rdata", inst_rdata, m_hold);
        chk("data_rdata", data_rdata, m_hold);
        if (e_arv) begin
            chk("araddr", araddr, m_addr);
            chk("arsize", arsize, {1'b0, m_size});
        end
        if (e_awv) begin
            chk("awaddr", awaddr, m_addr);
            chk("awsize", awsize, {1'b0, m_size});
        end
        if (e_wv) begin
            chk("wdata", wdata, m_wdata);
            chk("wstrb", wstrb, m_wstrb);
        end
        if (arvalid) cnt_ar++;
        if (awvalid) cnt_aw++;
        if (wvalid) cnt_w++;
        if (data_data_ok) cnt_dok++;
        if (resetn) begin
            resp = 0;
            if (e_arv && arready) m_ar = 1;
            if (e_awv && awready) m_aw = 1;
            if (e_wv && wready) m_w = 1;
            if (e_rr && rvalid) begin
                m_hold = memval(m_addr);
                resp = 1;
            end
            if (e_br && bvalid) resp = 1;
            m_pend = resp;
            m_pinst = m_inst;
            if (resp) m_busy = 0;
            if (e_daok || e_iaok) begin
                m_busy = 1; m_ar = 0; m_aw = 0; m_w = 0;
                m_inst = e_iaok;
                m_wr = e_daok && data_wr;
                m_addr = e_daok ? data_addr : inst_addr;
                m_size = e_daok ? data_size : 2'd2;
                m_wdata = data_wdata;
                m_wstrb = data_wstrb;
            end
        end
    end

    task automatic inst_issue(input logic [31:0] a, output int acc);
        int n;
        n = 0; acc = -1;
        inst_req = 1'b1; inst_addr = a;
        do begin @(negedge clk); n++; end
        while (!inst_addr_ok && n < 200);
        if (!inst_addr_ok) begin
            n_chk++; n_fail++;
            $display("FAIL inst_accept_timeout: got none want addr_ok");
        end else acc = cyc;
        @(posedge clk); #1;
        inst_req = 1'b0;
    endtask

    task automatic data_issue(input logic wr, input logic [1:0] sz,
                              input logic [3:0] strb,
                              input logic [31:0] a,
                              input logic [31:0] wd, output int acc);
        int n;
        n = 0; acc = -1;
        data_req = 1'b1; data_wr = wr; data_size = sz;
        data_wstrb = strb; data_addr = a; data_wdata = wd;
        do begin @(negedge clk); n++; end
        while (!data_addr_ok && n < 200);
        if (!data_addr_ok) begin
            n_chk++; n_fail++;
            $display("FAIL data_accept_timeout: got none want addr_ok");
        end else acc = cyc;
        @(posedge clk); #1;
        data_req = 1'b0;
    endtask

    task automatic wait_ok(input bit is_inst, output int at);
        int n;
        n = 0; at = -1;
        do begin @(negedge clk); n++; end
        while (!(is_inst ? inst_data_ok : data_data_ok) && n < 200);
        if (!(is_inst ? inst_data_ok : data_data_ok)) begin
            n_chk++; n_fail++;
            $display("FAIL data_ok_timeout: got none want pulse");
        end else at = cyc;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got hang want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, c1, dc, ic, dok;
        int acc[3];
        repeat (2) @(negedge clk);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_rdata", inst_rdata, 0);
        @(posedge clk); #1 resetn = 1'b1;

        // fetch from the boot vector
        @(posedge clk); #1;
        inst_issue(32'hBFC00000, c0);
        @(negedge clk);
        chk("t1_arvalid", arvalid, 1);
        chk("t1_araddr", araddr, 32'hBFC00000);
        chk("t1_arsize", arsize, 3'd2);
        wait_ok(1, c1);
        chk("t1_latency", c1 - c0, 3);
        chk("t1_rdata", inst_rdata, 32'h3C1DBFC0);

        // same-cycle conflict, data wins
        @(posedge clk); #1;
        fork
            begin
                data_issue(0, 2'd2, 4'hF, 32'h80001000, 0, dc);
                wait_ok(0, dok);
            end
            inst_issue(32'hBFC00004, ic);
        join
        chk("t2_data_first", ic > dc, 1);
        chk("t2_inst_on_dok", ic, dok);
        chk("t2_load_rdata", data_rdata, 32'h25A51000);
        wait_ok(1, c1);
        chk("t2_fetch_rdata", inst_rdata, 32'h1A650004);

        // byte store, awready late
        aw_dly = 3;
        @(posedge clk); #1;
        cnt_aw = 0; cnt_w = 0; cnt_dok = 0;
        data_issue(1, 2'd0, 4'b0100, 32'h80000002, 32'h00AA0000, c0);
        @(negedge clk);
        chk("t3_awaddr", awaddr, 32'h80000002);
        chk("t3_awsize", awsize, 3'd0);
        chk("t3_wstrb", wstrb, 4'b0100);
        chk("t3_wdata", wdata, 32'h00AA0000);
        wait_ok(0, c1);
        repeat (3) @(negedge clk);
        chk("t3_latency", c1 - c0, 6);
        chk("t3_aw_cycles", cnt_aw, 4);
        chk("t3_w_cycles", cnt_w, 1);
        chk("t3_one_pulse", cnt_dok, 1);

        // slow arready and rvalid
        aw_dly = 0; ar_dly = 5; r_dly = 2;
        @(posedge clk); #1;
        cnt_ar = 0; cnt_dok = 0;
        data_issue(0, 2'd2, 4'hF, 32'h80000010, 0, c0);
        wait_ok(0, c1);
        repeat (3) @(negedge clk);
        chk("t4_latency", c1 - c0, 10);
        chk("t4_ar_cycles", cnt_ar, 6);
        chk("t4_one_pulse", cnt_dok, 1);
        chk("t4_rdata", data_rdata, 32'h25A50010);

        // reset while waiting in R
        ar_dly = 0; r_dly = 20;
        @(posedge clk); #1;
        inst_issue(32'hBFC00008, c0);
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        chk("t5_arvalid", arvalid, 0);
        chk("t5_rready", rready, 0);
        chk("t5_awvalid", awvalid, 0);
        chk("t5_wvalid", wvalid, 0);
        chk("t5_bready", bready, 0);
        chk("t5_iok", inst_data_ok, 0);
        chk("t5_dok", data_data_ok, 0);
        chk("t5_rdata", inst_rdata, 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1; r_dly = 0;
        inst_issue(32'hBFC00010, c0);
        wait_ok(1, c1);
        chk("t5_latency", c1 - c0, 3);
        chk("t5_fetch", inst_rdata, 32'h1A650010);

        // back-to-back loads
        @(posedge clk); #1;
        cnt_dok = 0;
        for (int i = 0; i < 3; i++)
            data_issue(0, 2'd2, 4'hF, 32'h80000100 + 32'(4 * i), 0, acc[i]);
        wait_ok(0, c1);
        repeat (2) @(negedge clk);
        chk("t6_gap01", acc[1] - acc[0], 3);
        chk("t6_gap12", acc[2] - acc[1], 3);
        chk("t6_last_ok", c1 - acc[2], 3);
        chk("t6_pulses", cnt_dok, 3);
        chk("t6_rdata", data_rdata, 32'h25A50108);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
